// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that serialises per-core data-memory
// requests onto one single-port, synchronous-read memory.
// Ports: clk/RESET; per-core addr, wdata, read, write, end flags in;
// core_ack (one-hot pulse) and broadcast core_rdata out; mem_* drive the
// memory; busy, grant_id, sticky conflict_err and all_done report status.
module dmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [N_CORES*AW-1:0] core_addr,
  input  logic [N_CORES*DW-1:0] core_wdata,
  input  logic [N_CORES-1:0]    core_read,
  input  logic [N_CORES-1:0]    core_write,
  input  logic [N_CORES-1:0]    core_end,
  output logic [N_CORES-1:0]    core_ack,
  output logic [DW-1:0]         core_rdata,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic                  conflict_err,
  output logic                  all_done
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state;

  logic [2:0]         ptr;
  logic               op_wr;
  logic               rd_sel;
  logic [DW-1:0]      rdata_q;
  logic [N_CORES-1:0] pend;
  logic [N_CORES-1:0] onehot;
  logic               found;
  logic               win_rd;
  logic               win_wr;
  logic [2:0]         win;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_wdata;
  int                 j;

  assign pend = core_read | core_write;

  // First pending core searching upward from ptr, wrapping around.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_rd    = 1'b0;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    onehot    = '0;
    j         = 0;
    for (int k = 0; k < N_CORES; k++) begin
      j      = (int'(ptr) + k) % N_CORES;
      onehot = N_CORES'(1) << j;
      if (!found && (pend & onehot) != '0) begin
        found     = 1'b1;
        win       = 3'(j);
        win_rd    = |(core_read & onehot);
        win_wr    = |(core_write & onehot);
        win_addr  = AW'(core_addr >> (AW * j));
        win_wdata = DW'(core_wdata >> (DW * j));
      end
    end
  end

  // Memory output is itself a register: pass it through during the
  // read's DONE cycle, then hold a copy for later cycles.
  assign core_rdata = rd_sel ? mem_rdata : rdata_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      ptr          <= '0;
      op_wr        <= 1'b0;
      rd_sel       <= 1'b0;
      rdata_q      <= '0;
      core_ack     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      conflict_err <= 1'b0;
      all_done     <= 1'b0;
    end else begin
      all_done <= &core_end;
      unique case (state)
        IDLE: begin
          core_ack <= '0;
          if (found) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            grant_id  <= win;
            op_wr     <= win_wr;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_we    <= win_wr;
            mem_re    <= !win_wr;
            if (win_rd && win_wr)
              conflict_err <= 1'b1;
          end
        end
        ACCESS: begin
          mem_we   <= 1'b0;
          mem_re   <= 1'b0;
          core_ack <= N_CORES'(1) << grant_id;
          rd_sel   <= !op_wr;
          state    <= DONE;
        end
        DONE: begin
          core_ack <= '0;
          if (rd_sel)
            rdata_q <= mem_rdata;
          rd_sel <= 1'b0;
          busy   <= 1'b0;
          ptr    <= (grant_id == 3'(N_CORES - 1)) ?
                    3'd0 : grant_id + 3'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
